uart_cmd_assembler: RTL and testbench
=====================================

// Module: uart_cmd_assembler
// PURPOSE
//  Downstream consumer of the UART byte receiver (rx_data/rdy/clr_rdy). Collects NUM_BYTES
//  received bytes, MSB-first, into one command word. Presents the word to the command
//  decoder with a cmd_rdy/clr_cmd_rdy handshake. Discards partial commands after an
//  inter-byte timeout and flags bytes lost while a command is held.
// PARAMETERS
//  NUM_BYTES     2        bytes per command; CMD_W = 8*NUM_BYTES
//  TIMEOUT_CLKS  104160   idle clks allowed between bytes of one command (~4 byte times @19200/50MHz)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      reset, asynchronous, active-low
//  rx_data      in   8      byte from receiver, valid while rx_rdy
//  rx_rdy       in   1      receiver byte-ready level
//  clr_rx_rdy   out  1      consume pulse to receiver (combinational, 1 clk)
//  cmd          out  CMD_W  assembled command; stable while cmd_rdy
//  cmd_rdy      out  1      command valid level
//  clr_cmd_rdy  in   1      decoder acknowledge; releases cmd
//  timeout_err  out  1      1-clk pulse when a partial command is discarded
//  overrun      out  1      sticky: byte lost while cmd held
// BEHAVIOUR
//  Reset: state=IDLE, byte_cnt=0, tmr=0, cmd=0, cmd_rdy=0, timeout_err=0, overrun=0.
//    clr_rx_rdy=0 during reset.
//  States: IDLE (byte_cnt==0), COLLECT (0<byte_cnt<NUM_BYTES), FULL (cmd_rdy=1).
//  Accept: in IDLE/COLLECT, rx_rdy=1 -> clr_rx_rdy=1 that cycle.
//    Same edge: cmd <= {cmd[CMD_W-9:0], rx_data}, byte_cnt++, tmr<=0.
//    Exactly one byte per rx_rdy assertion; the receiver drops rdy the following clk.
//  Last byte (byte_cnt==NUM_BYTES-1) accepted -> byte_cnt<=0, cmd_rdy<=1, state FULL.
//    cmd_rdy rises 1 clk after clr_rx_rdy. Latency rx_rdy->cmd_rdy = 1 clk.
//  FULL: rx_rdy ignored; clr_rx_rdy=0; cmd frozen.
//    clr_cmd_rdy=1 -> cmd_rdy<=0, overrun<=0, state IDLE.
//    A byte still pending (rx_rdy high) is accepted on the next clk as byte 0.
//  Simultaneous clr_cmd_rdy & rx_rdy in FULL: the release wins; the byte is accepted the following clk.
//  clr_cmd_rdy outside FULL: no effect.
//  Overrun: register rx_rdy_q. Detect rx_rdy_q=1 & rx_rdy=0 & prior-cycle clr_rx_rdy=0
//    (receiver dropped an unconsumed byte) -> overrun<=1.
//    overrun holds until clr_cmd_rdy or reset.
//  Timeout: tmr counts only in COLLECT with no accept, saturating.
//    tmr==TIMEOUT_CLKS-1 -> byte_cnt<=0, cmd<=0, tmr<=0, timeout_err=1 for 1 clk, state IDLE.
//    Accept on that same cycle wins: no timeout, byte taken.
//  tmr width $clog2(TIMEOUT_CLKS). byte_cnt width $clog2(NUM_BYTES+1).
//    All counters cleared on IDLE entry.
//  Reset mid-command: partial bytes are lost; no cmd_rdy results.
// STRUCTURE
//  uart_pkg: typedef enum logic[1:0] {IDLE,COLLECT,FULL} asm_state_t;
//    localparam DEF_TIMEOUT_CLKS=104160.
//  Sub-module uart_byte_timer: clear/enable/expire counter, param TIMEOUT_CLKS.
//  Rest inline: FSM, shift register, overrun edge detect.
// TESTING (bench instantiates UART_tx->UART_rx->uart_cmd_assembler, plus direct-drive mode)
//  1 Bytes 0xA5, 0x3C -> cmd=16'hA53C, cmd_rdy 1 clk after 2nd clr_rx_rdy, two clr_rx_rdy pulses.
//  2 0x12, then idle TIMEOUT_CLKS -> timeout_err pulse, no cmd_rdy.
//    Then 0x34, 0x56 -> cmd=16'h3456.
//  3 Hold cmd_rdy (no clr), send 0x77 -> clr_rx_rdy stays 0.
//    clr_cmd_rdy -> 0x77 accepted next clk as byte 0.
//  4 Hold cmd_rdy, send 0x11 then 0x22 -> receiver drops rdy, overrun=1.
//    clr_cmd_rdy -> overrun=0.
//  5 Assert rst_n=0 after 1st byte 0xFF -> all outputs 0.
//    Then 0x01, 0x02 -> cmd=16'h0102.
//  6 clr_cmd_rdy and rx_rdy same clk in FULL -> cmd_rdy=0 next clk.
//    Byte accepted the following clk, no overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART command assembler.
package uart_pkg;

    // Assembler states: no bytes held / partial command / complete command held.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } asm_state_t;

    // Roughly four byte times at 19200 baud from a 50 MHz clock.
    localparam int DEF_TIMEOUT_CLKS = 104160;
    localparam int DEF_NUM_BYTES    = 2;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle timer: counts enabled cycles, saturates at the expiry value,
// and flags expiry while the count sits at TIMEOUT_CLKS-1.
module uart_byte_timer
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int            TW   = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CLKS - 1);

    logic [TW-1:0] r_tmr;

    // Clear has priority; counting stops at the expiry value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= '0;
        end else if (i_clr) begin
            r_tmr <= '0;
        end else if (i_en && (r_tmr != LAST)) begin
            r_tmr <= r_tmr + TW'(1);
        end
    end

    assign o_expire = (r_tmr == LAST);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Collects NUM_BYTES received bytes MSB-first into one command word and hands it
// to the decoder with a level/acknowledge handshake. Partial commands are dropped
// after an inter-byte timeout; bytes the receiver loses while a command is held
// raise a sticky overrun flag.
module uart_cmd_assembler
    import uart_pkg::*;
#(
    parameter int NUM_BYTES    = DEF_NUM_BYTES,
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_rdy,
    output logic                   clr_rx_rdy,
    output logic [8*NUM_BYTES-1:0] cmd,
    output logic                   cmd_rdy,
    input  logic                   clr_cmd_rdy,
    output logic                   timeout_err,
    output logic                   overrun
);

    localparam int            CMD_W     = 8 * NUM_BYTES;
    localparam int            CW        = $clog2(NUM_BYTES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NUM_BYTES - 1);

    asm_state_t     r_state;
    asm_state_t     w_state_nxt;
    logic [CW-1:0]  r_byte_cnt;
    logic [CMD_W-1:0] r_cmd;
    logic [CMD_W-1:0] w_cmd_shift;
    logic           r_overrun;
    logic           r_rx_rdy_q;
    logic           r_clr_q;
    logic           w_accept;
    logic           w_timeout;
    logic           w_release;
    logic           w_last;
    logic           w_expire;
    logic           w_drop;
    logic           w_tmr_clr;
    logic           w_tmr_en;

    assign w_last      = (r_byte_cnt == LAST_BYTE);
    assign w_cmd_shift = (r_cmd << 8) | CMD_W'(rx_data);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake decode; an accepted byte beats a same-cycle timeout,
    // and a release in FULL beats a pending byte (taken the cycle after).
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_rdy) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_last ? FULL : COLLECT;
                end
            end
            COLLECT: begin
                if (rx_rdy) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_last ? FULL : COLLECT;
                end else if (w_expire) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            FULL: begin
                if (clr_cmd_rdy) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift register and byte counter; a timeout wipes the partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd      <= '0;
            r_byte_cnt <= '0;
        end else if (w_accept) begin
            r_cmd      <= w_cmd_shift;
            r_byte_cnt <= w_last ? '0 : r_byte_cnt + CW'(1);
        end else if (w_timeout || w_release) begin
            r_byte_cnt <= '0;
            if (w_timeout) begin
                r_cmd <= '0;
            end
        end
    end

    // Lost-byte detect: receiver dropped rdy without our consume pulse last cycle.
    assign w_drop = r_rx_rdy_q & ~rx_rdy & ~r_clr_q;

    // Overrun flag is sticky until the held command is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_rdy_q <= 1'b0;
            r_clr_q    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rx_rdy_q <= rx_rdy;
            r_clr_q    <= w_accept;
            if (w_release) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Timer only runs while a partial command waits for its next byte.
    assign w_tmr_clr = (r_state != COLLECT) | w_accept | w_timeout;
    assign w_tmr_en  = (r_state == COLLECT) & ~w_accept;

    uart_byte_timer #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    assign clr_rx_rdy  = w_accept & rst_n;
    assign cmd         = r_cmd;
    assign cmd_rdy     = (r_state == FULL);
    assign timeout_err = w_timeout;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler: directed scenarios plus randomized traffic, with a
// queue-based command model compared against the DUT on every clock.
module tb_uart_cmd_assembler;

    localparam int NB = 2;
    localparam int T  = 50;
    localparam int CW = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_rdy = 1'b0;
    logic          clr_rx_rdy;
    logic [CW-1:0] cmd;
    logic          cmd_rdy;
    logic          clr_cmd_rdy = 1'b0;
    logic          timeout_err;
    logic          overrun;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int clr_cnt = 0;
    int to_cnt = 0;
    int last_clr_cyc = 0;
    int rise_cyc = 0;
    bit saw_clr = 1'b0;
    bit saw_rdy = 1'b0;
    bit pend_q = 1'b0;
    logic [7:0] pend_b = 8'h00;

    // Model: bytes of the partial command, held command, idle run, overrun.
    logic [7:0]    m_q[$];
    bit            m_full = 1'b0;
    logic [CW-1:0] m_cmd = '0;
    int            m_idle = 0;
    bit            m_ovr = 1'b0;
    bit            m_prev_rdy = 1'b0;
    bit            m_prev_clr = 1'b0;

    uart_cmd_assembler #(
        .NUM_BYTES    (NB),
        .TIMEOUT_CLKS (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model, then advance the model past the next edge.
    always @(negedge clk) begin
        bit acc;
        bit tmo;
        bit drop;
        logic [CW-1:0] v;
        if (!rst_n) begin
            chk("rst_clr_rx_rdy", clr_rx_rdy, 0);
            chk("rst_cmd_rdy", cmd_rdy, 0);
            chk("rst_cmd", cmd, 0);
            chk("rst_timeout_err", timeout_err, 0);
            chk("rst_overrun", overrun, 0);
            m_q.delete();
            m_full = 1'b0;
            m_idle = 0;
            m_ovr = 1'b0;
            m_prev_rdy = 1'b0;
            m_prev_clr = 1'b0;
            saw_clr = 1'b0;
            saw_rdy = 1'b0;
        end else begin
            acc = rx_rdy && !m_full;
            tmo = !acc && (m_q.size() > 0) && (m_idle + 1 == T);
            chk("clr_rx_rdy", clr_rx_rdy, acc);
            chk("timeout_err", timeout_err, tmo);
            chk("cmd_rdy", cmd_rdy, m_full);
            chk("overrun", overrun, m_ovr);
            if (m_full) chk("cmd", cmd, m_cmd);
            if (clr_rx_rdy) begin
                clr_cnt++;
                last_clr_cyc = cyc;
            end
            if (timeout_err) to_cnt++;
            if (cmd_rdy && !saw_rdy) rise_cyc = cyc;
            saw_clr = clr_rx_rdy;
            saw_rdy = cmd_rdy;

            drop = m_prev_rdy && !rx_rdy && !m_prev_clr;
            if (m_full && clr_cmd_rdy) begin
                m_full = 1'b0;
                m_ovr = 1'b0;
            end else if (drop) begin
                m_ovr = 1'b1;
            end
            if (acc) begin
                m_q.push_back(rx_data);
                m_idle = 0;
                if (m_q.size() == NB) begin
                    v = '0;
                    foreach (m_q[k]) v = (v << 8) | CW'(m_q[k]);
                    m_cmd = v;
                    m_full = 1'b1;
                    m_q.delete();
                end
            end else if (m_q.size() > 0) begin
                if (tmo) begin
                    m_q.delete();
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
            end
            m_prev_rdy = rx_rdy;
            m_prev_clr = acc;
        end
    end

    // One clock of stimulus: receiver emulation (rdy held until consumed; a new byte
    // arriving while one is pending drops rdy for a clock) plus decoder acknowledge.
    task automatic drive_cycle(input bit nb, input logic [7:0] b, input bit ack);
        @(posedge clk);
        #1;
        clr_cmd_rdy = ack;
        if (pend_q) begin
            rx_rdy = 1'b1;
            rx_data = pend_b;
            pend_q = 1'b0;
        end else if (rx_rdy && saw_clr) begin
            rx_rdy = 1'b0;
        end else if (nb) begin
            if (rx_rdy) begin
                rx_rdy = 1'b0;
                pend_q = 1'b1;
                pend_b = b;
            end else begin
                rx_rdy = 1'b1;
                rx_data = b;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        drive_cycle(1'b1, b, 1'b0);
    endtask

    task automatic ack();
        drive_cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx_rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        pend_q = 1'b0;
        #2;
        chk("reset_outputs", {cmd_rdy, clr_rx_rdy, timeout_err, overrun}, 0);
        chk("reset_cmd", cmd, 0);
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int c0;
        int t0;
        do_reset(3);

        // 1: two bytes assemble MSB-first, cmd_rdy one clock after the last consume.
        c0 = clr_cnt;
        send(8'hA5); idle(2);
        send(8'h3C); idle(2);
        #2;
        chk("t1_cmd_rdy", cmd_rdy, 1);
        chk("t1_cmd", cmd, 16'hA53C);
        chk("t1_model_cmd", m_cmd, 16'hA53C);
        chk("t1_clr_pulses", clr_cnt - c0, 2);
        chk("t1_latency", rise_cyc - last_clr_cyc, 1);
        ack(); idle(2);

        // 2: partial command discarded after the idle limit, then a clean command.
        t0 = to_cnt;
        send(8'h12); idle(T + 5);
        #2;
        chk("t2_timeouts", to_cnt - t0, 1);
        chk("t2_no_cmd_rdy", cmd_rdy, 0);
        send(8'h34); idle(2);
        send(8'h56); idle(2);
        #2;
        chk("t2_cmd", cmd, 16'h3456);
        chk("t2_model_cmd", m_cmd, 16'h3456);

        // 3: byte arriving while held is not consumed until release.
        c0 = clr_cnt;
        send(8'h77); idle(3);
        #2;
        chk("t3_clr_held", clr_cnt - c0, 0);
        chk("t3_cmd_held", cmd, 16'h3456);
        ack();
        #2;
        chk("t3_clr_on_release", clr_rx_rdy, 0);
        idle(1);
        #2;
        chk("t3_released", cmd_rdy, 0);
        chk("t3_accept_next", clr_rx_rdy, 1);
        idle(2);
        send(8'h88); idle(2);
        #2;
        chk("t3_cmd", cmd, 16'h7788);
        chk("t3_no_overrun", overrun, 0);

        // 4: second byte while held -> receiver drops the first -> overrun.
        send(8'h11); idle(2);
        send(8'h22); idle(3);
        #2;
        chk("t4_overrun_set", overrun, 1);
        ack(); idle(1);
        #2;
        chk("t4_overrun_clr", overrun, 0);
        idle(2);
        send(8'h33); idle(2);
        #2;
        chk("t4_cmd", cmd, 16'h2233);
        ack(); idle(2);

        // 5: reset mid-command loses the partial byte.
        send(8'hFF); idle(2);
        do_reset(3);
        idle(2);
        send(8'h01); idle(1);
        send(8'h02); idle(2);
        #2;
        chk("t5_cmd", cmd, 16'h0102);
        ack(); idle(2);

        // Randomized traffic: alternating bursty and sparse phases, random acks/resets.
        for (int i = 0; i < 4000; i++) begin
            int p;
            bit a;
            p = (((i / 500) % 2) == 0) ? 30 : 3;
            a = saw_rdy ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
            if ($urandom_range(999) == 0) do_reset(2);
            else drive_cycle($urandom_range(99) < p, 8'($urandom), a);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
